// File: rtl/wb_queue.sv
// Register-file write-back arbiter: single-cycle ALU results take priority over a
// small FIFO of LSU results, with a starvation counter that lets the FIFO head preempt.
module wb_queue #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        alu_valid,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_wdata,
  output logic        alu_stall,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_waddr,
  input  logic [31:0] lsu_wdata,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        q_hit1,
  output logic        q_hit2
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

  // Handshake: an LSU result transfers on a cycle where lsu_valid && lsu_ready at posedge;
  // lsu_ready never depends on lsu_valid or on a same-cycle pop. The ALU side has no
  // ready: alu_stall tells upstream to re-present the same result next cycle.

  logic [4:0]       mem_addr_q [DEPTH];
  logic [31:0]      mem_data_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
  logic             we_q, we_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic fifo_empty, starve_active, grant_alu, grant_fifo, push;

  always_comb begin
    fifo_empty    = (count_q == '0);
    starve_active = (starve_cnt_q == SW'(STARVE_LIMIT)) && !fifo_empty;
    lsu_ready     = (count_q < CNT_W'(DEPTH)) && !flush && !rst;
    alu_stall     = alu_valid && starve_active && !flush && !rst;
    grant_alu     = alu_valid && !starve_active && !flush && !rst;
    grant_fifo    = !fifo_empty && (!alu_valid || starve_active) && !flush && !rst;
    // Writes to r0 complete the handshake but are never stored.
    push          = lsu_valid && lsu_ready && (lsu_waddr != 5'd0);
  end

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    starve_cnt_d = starve_cnt_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    if (flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      starve_cnt_d = '0;
    end else begin
      if (grant_alu) begin
        we_d    = (alu_waddr != 5'd0);
        waddr_d = alu_waddr;
        wdata_d = alu_wdata;
      end else if (grant_fifo) begin
        we_d    = 1'b1;
        waddr_d = mem_addr_q[rd_ptr_q];
        wdata_d = mem_data_q[rd_ptr_q];
      end
      if (grant_fifo || fifo_empty) begin
        starve_cnt_d = '0;
      end else if (grant_alu && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
      if (grant_fifo) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push)       wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(grant_fifo);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= lsu_waddr;
      mem_data_q[wr_ptr_q] <= lsu_wdata;
    end
  end

  // An entry is live when its distance from the read pointer (mod DEPTH) is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        if ((q_addr1 != 5'd0) && (mem_addr_q[i] == q_addr1)) q_hit1 = 1'b1;
        if ((q_addr2 != 5'd0) && (mem_addr_q[i] == q_addr2)) q_hit2 = 1'b1;
      end
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios then random traffic, each cycle checked
// against a queue-based model of the write-back rules.
module tb_wb_queue;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        alu_valid;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        alu_stall;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  q_addr1, q_addr2;
  logic        q_hit1, q_hit2;

  int tests_run = 0;
  int failures  = 0;

  // Scoreboard: queued LSU results in arrival order, {addr, data}.
  logic [36:0] exp_q[$];
  int          starve_m;
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;

  wb_queue #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(q_hit1), .q_hit2(q_hit2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hit(input logic [4:0] a);
    logic h = 1'b0;
    foreach (exp_q[i]) if (a != 5'd0 && exp_q[i][36:32] == a) h = 1'b1;
    return h;
  endfunction

  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // advance the model, check the registered write port after the edge.
  task automatic step(input logic r, input logic f, input logic av, input logic [4:0] aa,
                      input logic [31:0] ad, input logic lv, input logic [4:0] la,
                      input logic [31:0] ld);
    logic        e_ready, starving, e_stall, do_push;
    logic [36:0] ent;
    rst = r; flush = f;
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    q_addr1 = 5'($urandom_range(0, 7));
    if (exp_q.size() != 0) begin
      ent = exp_q[$urandom_range(0, exp_q.size() - 1)];
      q_addr2 = ent[36:32];
    end else begin
      q_addr2 = 5'($urandom_range(0, 31));
    end
    e_ready  = (exp_q.size() < DEPTH) && !f && !r;
    starving = (starve_m == STARVE_LIMIT) && (exp_q.size() != 0);
    e_stall  = av && starving && !f && !r;
    @(negedge clk);
    chk("lsu_ready", 32'(lsu_ready), 32'(e_ready));
    chk("alu_stall", 32'(alu_stall), 32'(e_stall));
    chk("q_hit1", 32'(q_hit1), 32'(model_hit(q_addr1)));
    chk("q_hit2", 32'(q_hit2), 32'(model_hit(q_addr2)));
    if (r) begin
      exp_q.delete(); starve_m = 0;
      exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
    end else if (f) begin
      exp_q.delete(); starve_m = 0; exp_we = 1'b0;
    end else begin
      do_push = e_ready && lv && (la != 5'd0);
      if (av && !starving) begin
        exp_we = (aa != 5'd0); exp_waddr = aa; exp_wdata = ad;
        if (exp_q.size() == 0) starve_m = 0;
        else if (starve_m < STARVE_LIMIT) starve_m++;
      end else if (exp_q.size() != 0) begin
        ent = exp_q.pop_front();
        exp_we = 1'b1; exp_waddr = ent[36:32]; exp_wdata = ent[31:0];
        starve_m = 0;
      end else begin
        exp_we = 1'b0; starve_m = 0;
      end
      if (do_push) exp_q.push_back({la, ld});
    end
    @(posedge clk);
    #1;
    chk("we", 32'(we), 32'(exp_we));
    chk("waddr", 32'(waddr), 32'(exp_waddr));
    chk("wdata", wdata, exp_wdata);
  endtask

  task automatic idle(input int n, input logic av);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, av, 5'($urandom_range(1, 31)), $urandom, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    starve_m = 0; exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
    rst = 1'b1; flush = 1'b0; alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0; q_addr1 = '0; q_addr2 = '0;
    @(posedge clk); #1;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);

    // ALU only, including a write to r0
    step(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);
    idle(1, 1'b0);

    // LSU fill: five offers with the ALU busy; the fifth is refused
    for (int i = 1; i <= 5; i++)
      step(1'b0, 1'b0, 1'b1, 5'(20 + i), $urandom, 1'b1, 5'(i), 32'(32'hA000 + i));
    idle(12, 1'b1);
    idle(6, 1'b0);

    // Starvation: one queued entry, ALU busy throughout
    step(1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd7, 32'h7777);
    idle(12, 1'b1);

    // Drain order with the ALU idle
    for (int i = 1; i <= 3; i++)
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(32'hB000 + i));
    idle(4, 1'b0);

    // Flush with three entries queued, then reset with three entries queued
    for (int i = 1; i <= 3; i++)
      step(1'b0, 1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'(10 + i), 32'(i));
    step(1'b0, 1'b1, 1'b1, 5'd6, 32'h6, 1'b1, 5'd15, 32'h15);
    idle(2, 1'b0);
    for (int i = 1; i <= 3; i++)
      step(1'b0, 1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'(10 + i), 32'(i));
    step(1'b1, 1'b0, 1'b1, 5'd6, 32'h6, 1'b1, 5'd15, 32'h15);
    idle(3, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, LSU result FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, consecutive denied cycles before the FIFO head preempts ALU.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all queued LSU results.
REQ-006 SHALL have port alu_valid  input  1  single-cycle ALU result present this cycle.
REQ-007 SHALL have port alu_waddr  input  5  ALU destination register.
REQ-008 SHALL have port alu_wdata  input  32  ALU result.
REQ-009 SHALL have port alu_stall  output  1  ALU result not accepted this cycle, upstream re-presents it.
REQ-010 SHALL have port lsu_valid  input  1  LSU result offered.
REQ-011 SHALL have port lsu_ready  output  1  FIFO can accept an LSU result.
REQ-012 SHALL have port lsu_waddr  input  5  LSU destination register.
REQ-013 SHALL have port lsu_wdata  input  32  LSU result.
REQ-014 SHALL have port we  output  1  register file write enable, registered.
REQ-015 SHALL have port waddr  output  5  register file write address, registered.
REQ-016 SHALL have port wdata  output  32  register file write data, registered.
REQ-017 SHALL have ports q_addr1 / q_addr2  input  5 each  hazard query addresses from decode.
REQ-018 SHALL have ports q_hit1 / q_hit2  output  1 each  combinational: queried register has a pending queued write.

Function
REQ-019 SHALL drive exactly one write per cycle max; grant decided combinationally, write outputs loaded on the following posedge (1-cycle ALU latency).
REQ-020 SHALL grant ALU when alu_valid=1 and starvation not active; next cycle we=(alu_waddr!=0), waddr/wdata=alu inputs.
REQ-021 SHALL grant FIFO head when FIFO non-empty and (alu_valid=0 or starvation active); head popped, next cycle we=1 with head addr/data.
REQ-022 SHALL, with no grant, load we=0 and hold waddr/wdata.
REQ-023 SHALL keep 3-bit-or-wider starve_cnt: +1 each cycle ALU granted while FIFO non-empty; cleared on FIFO pop, FIFO empty, flush, rst; saturates at STARVE_LIMIT.
REQ-024 SHALL activate starvation when starve_cnt==STARVE_LIMIT and FIFO non-empty; that cycle alu_stall=alu_valid, ALU inputs ignored.
REQ-025 SHALL set alu_stall=0 in every other cycle, including flush and rst cycles.
REQ-026 SHALL push on lsu_valid && lsu_ready; lsu_waddr==0 completes the handshake but stores nothing.
REQ-027 SHALL drive lsu_ready = (count<DEPTH) && !flush && !rst, independent of a same-cycle pop (full + pop still refuses push).
REQ-028 SHALL not pop an entry in its push cycle; minimum LSU-to-we latency 2 cycles, FIFO order preserved.
REQ-029 SHALL wrap read/write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-030 SHALL on flush empty FIFO, suppress any grant (next cycle we=0), ignore ALU inputs and LSU offer.
REQ-031 SHALL assert q_hitN iff q_addrN!=0 and any valid FIFO entry holds waddr==q_addrN; output register and current ALU inputs excluded.
REQ-032 SHALL give rst priority over flush and all other inputs.

Reset
REQ-033 SHALL, while rst=1 at posedge, clear we, waddr, wdata, count, pointers, starve_cnt to 0.
REQ-034 SHALL hold lsu_ready=0, alu_stall=0 during rst; q_hit1/q_hit2=0 from the cycle after reset.
REQ-035 SHALL discard an entire queued backlog on reset mid-operation; no write emitted after rst.

Verification
REQ-036 SHALL cover ALU only: alu_valid=1, addr 5, data 0xDEADBEEF at cycle N -> we=1, waddr=5, wdata=0xDEADBEEF at N+1; addr 0 -> we=0.
REQ-037 SHALL cover LSU fill: 5 back-to-back offers, alu_valid=1 throughout -> first 4 accepted, lsu_ready=0 on 5th, q_hit on each queued addr.
REQ-038 SHALL cover starvation: 1 queued entry, alu_valid=1 continuously -> 8 ALU writes, 9th cycle alu_stall=1, FIFO entry written next cycle, ALU resumes.
REQ-039 SHALL cover drain order: LSU pushes addr 1,2,3 with alu_valid=0 -> we pulses addr 1,2,3 on consecutive cycles starting 2 cycles after first push.
REQ-040 SHALL cover flush/reset: 3 queued entries, flush=1 one cycle -> we=0 next cycle, q_hit=0, lsu_ready=1; repeat with rst -> all outputs 0.
